multicycle_control: RTL



---
 rtl/multicycle_control_pkg.sv | 63 ++++++
 rtl/multicycle_control_alu_decode.sv | 33 +++
 rtl/multicycle_control.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_defs (package)
// Description : Shared definitions for the multicycle control FSM: state
//               encoding, opcode/funct constants, ALUOp codes and the
//               ALUSrcB / PCSource mux select codes.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_defs;

  // state_dbg exposes this encoding directly, so the values are fixed.
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEMADR  = 4'd3,
    MEMRD   = 4'd4,
    MEMWB   = 4'd5,
    MEMWR   = 4'd6,
    RTEX    = 4'd7,
    ALUWB   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    BEQ     = 4'd11,
    JUMP    = 4'd12,
    ILLEGAL = 4'd13
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALUOp codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;

  // ALUSrcB selects
  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PCSource selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_alu_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_decode
// Description : Combinational R-type funct -> ALUOp translation with a
//               funct-valid flag for unsupported encodings.
// Ports       : funct       in  6  IR[5:0]
//               alu_op      out 4  ALUOp code (ADD when funct is invalid)
//               funct_valid out 1  funct is a supported R-type operation
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decode
  import mc_defs::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       funct_valid
);

  always_comb begin
    alu_op      = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Control FSM for the multicycle datapath. Drives all datapath
//               strobes, waits on mem_ready for memory accesses, traps
//               illegal instructions (sticky until reset) and counts retired
//               instructions.
// Ports       : clk, reset (async, active-low), opcode/funct (IR fields),
//               mem_ready (memory access completes this cycle),
//               datapath strobes PCWrite..RegDst, PCSource[1:0],
//               ALUSrcB[1:0], ALUOp[3:0], state_dbg[3:0], instr_done,
//               illegal_op, instr_count[COUNT_W-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
  import mc_defs::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               RegDst,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUSrcB,
  output logic [3:0]         ALUOp,
  output logic [3:0]         state_dbg,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [COUNT_W-1:0] instr_count
);

  state_t             state;
  state_t             next_state;
  logic               store_op;      // lw/sw choice captured in DECODE
  logic [3:0]         rtype_alu_op;  // R-type ALUOp captured in DECODE
  logic [3:0]         dec_alu_op;
  logic               dec_funct_valid;
  logic [COUNT_W-1:0] retired_count;

  alu_decode u_alu_decode (
    .funct       (funct),
    .alu_op      (dec_alu_op),
    .funct_valid (dec_funct_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The IR fields are only trusted in DECODE; anything needed later in the
  // instruction is captured here so later IR changes cannot disturb it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      store_op     <= 1'b0;
      rtype_alu_op <= ALU_ADD;
    end else if (state == DECODE) begin
      store_op     <= (opcode == OP_SW);
      rtype_alu_op <= dec_alu_op;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_count <= '0;
    end else if (instr_done) begin
      retired_count <= retired_count + COUNT_W'(1);
    end
  end

  always_comb begin
    next_state  = state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUSrcB     = SRCB_REGB;
    ALUOp       = ALU_ADD;
    instr_done  = 1'b0;

    case (state)
      IDLE: next_state = FETCH;

      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        // PC and IR update only on the cycle the instruction word arrives.
        PCWrite = mem_ready;
        IRWrite = mem_ready;
        if (mem_ready) next_state = DECODE;
      end

      DECODE: begin
        // Speculative branch target computed into ALUOut.
        ALUSrcB = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = dec_funct_valid ? RTEX : ILLEGAL;
          OP_ADDI:      next_state = ADDIEX;
          OP_BEQ:       next_state = BEQ;
          OP_J:         next_state = JUMP;
          default:      next_state = ILLEGAL;
        endcase
      end

      MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        next_state = store_op ? MEMWR : MEMRD;
      end

      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) next_state = MEMWB;
      end

      MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        next_state = FETCH;
      end

      MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) next_state = FETCH;
      end

      RTEX: begin
        ALUSrcA    = 1'b1;
        ALUOp      = rtype_alu_op;
        next_state = ALUWB;
      end

      ALUWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
        next_state = FETCH;
      end

      ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        next_state = ADDIWB;
      end

      ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        next_state = FETCH;
      end

      BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        instr_done  = 1'b1;
        next_state  = FETCH;
      end

      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = PCSRC_JUMP;
        instr_done = 1'b1;
        next_state = FETCH;
      end

      ILLEGAL: next_state = ILLEGAL;

      // Unused encodings are treated as a corrupted state and trapped.
      default: next_state = ILLEGAL;
    endcase
  end

  // ILLEGAL is absorbing until reset, so decoding the state is sticky.
  assign illegal_op  = (state == ILLEGAL);
  assign state_dbg   = state;
  assign instr_count = retired_count;

endmodule
`default_nettype wire
